uart_cmd_rx: RTL and testbench

Parametrised multi-channel UART command receiver for controller input.
- Each of N_CH channels is an independent 8N1 receiver with mid-bit sampling.
- A received byte becomes a held 7-bit button vector per player, cleared automatically when frames stop arriving.
- Sits between the GPIO UART pins and the game top on the 108 MHz clock.
- Adds framing-error detection, glitch rejection, hold/timeout and link status per channel.

---
 rtl/uart_cmd_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: multi-channel 8N1 UART command receiver.
// Each channel synchronises its serial line, decodes 8N1 frames with
// mid-bit sampling, and turns command bytes (bit 7 clear) into a held
// 7-bit button vector that expires HOLD_CYCLES-1 cycles after the last
// good command. Control bytes (bit 7 set) update o_data/o_valid only.
module uart_cmd_rx #(
  parameter int N_CH         = 2,
  parameter int CLKS_PER_BIT = 938,
  parameter int HOLD_CYCLES  = 5400000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_rx,
  output logic [8*N_CH-1:0] o_data,
  output logic [N_CH-1:0]   o_valid,
  output logic [7*N_CH-1:0] o_cmd,
  output logic [N_CH-1:0]   o_frame_err,
  output logic [N_CH-1:0]   o_link
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             good;
    logic             ferr;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic [6:0]       cmd_q;
    logic [TMR_W-1:0] timer;

    // Two-flop synchroniser for the asynchronous serial line.
    // NOTE: presetting to 1 (the idle level) stops reset release from
    // looking like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rx_meta <= 1'b1;
        rx_s    <= 1'b1;
      end else begin
        // NOTE: non-blocking assignments let both flops sample the
        // pre-edge values, so this really is two stages and not one.
        rx_meta <= i_rx[c];
        rx_s    <= rx_meta;
      end
    end

    // Receiver state register together with its bit timer and shifter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state   <= S_IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        state   <= state_n;
        cnt     <= cnt_n;
        bit_idx <= bit_idx_n;
        shreg   <= shreg_n;
      end
    end

    // Next-state logic: mid-bit sampling of start, data and stop bits.
    always_comb begin
      // NOTE: every output of this block gets a default first so no
      // path through the case can leave one unassigned (no latches).
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      good      = 1'b0;
      ferr      = 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_n   = HALF_LOAD;
            state_n = S_START;
          end
        end

        S_START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              // Line went back high before mid start bit: a glitch.
              state_n = S_IDLE;
            end else begin
              cnt_n     = BIT_LOAD;
              bit_idx_n = '0;
              state_n   = S_DATA;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == '0) begin
            shreg_n = {rx_s, shreg[7:1]};
            cnt_n   = BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state_n = S_STOP;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              good    = 1'b1;
              state_n = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_n = S_WAIT_HIGH;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // A line held low (break) must return high before a new start.
          if (rx_s) begin
            state_n = S_IDLE;
          end
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end

    // Output registers: byte/valid/error pulses and the command hold timer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        cmd_q   <= '0;
        timer   <= '0;
      end else begin
        valid_q <= good;
        ferr_q  <= ferr;
        if (good) begin
          data_q <= shreg;
        end
        if (good && !shreg[7]) begin
          // A fresh command wins over an expiry on the same edge.
          cmd_q <= shreg[6:0];
          timer <= HOLD_LOAD;
        end else if (timer != '0) begin
          timer <= timer - 1'b1;
          if (timer == TMR_ONE) begin
            cmd_q <= '0;
          end
        end
      end
    end

    assign o_data[8*c +: 8]  = data_q;
    assign o_valid[c]        = valid_q;
    assign o_frame_err[c]    = ferr_q;
    assign o_cmd[7*c +: 7]   = cmd_q;
    assign o_link[c]         = (timer != '0);

  end : g_ch

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx with two channels,
// 16 clocks per bit and a 1000-cycle hold.
module tb_uart_cmd_rx;

  localparam int N_CH = 2;
  localparam int CPB  = 16;
  localparam int HOLD = 1000;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   rx    = '1;
  logic [8*N_CH-1:0] o_data;
  logic [N_CH-1:0]   o_valid;
  logic [7*N_CH-1:0] o_cmd;
  logic [N_CH-1:0]   o_frame_err;
  logic [N_CH-1:0]   o_link;

  int errors = 0;
  int checks = 0;

  uart_cmd_rx #(
    .N_CH        (N_CH),
    .CLKS_PER_BIT(CPB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_cmd      (o_cmd),
    .o_frame_err(o_frame_err),
    .o_link     (o_link)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge away from DUT updates.
  int              cyc       = 0;
  int              vcnt [2]  = '{0, 0};
  int              ecnt [2]  = '{0, 0};
  int              last_v [2] = '{0, 0};
  int              link_fall [2] = '{0, 0};
  int              both_cnt  = 0;
  logic [N_CH-1:0] link_prev = '0;

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (o_valid[c]) begin
        vcnt[c]++;
        last_v[c] = cyc;
      end
      if (o_frame_err[c]) ecnt[c]++;
      if (link_prev[c] && !o_link[c]) link_fall[c] = cyc;
    end
    if (o_valid == 2'b11) both_cnt++;
    link_prev = o_link;
  end

  task automatic send_bit(input int c, input logic b);
    rx[c] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int c, input logic [7:0] b, input logic stop);
    send_bit(c, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(c, b[i]);
    send_bit(c, stop);
  endtask

  task automatic wait_link_low(input int c);
    for (int i = 0; i < HOLD + 200 && o_link[c]; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_data, o_valid, o_cmd, o_frame_err, o_link} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b cmd=%h ferr=%b link=%b, expected all 0",
               o_data, o_valid, o_cmd, o_frame_err, o_link);
    end
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if ({o_data, o_valid, o_cmd, o_frame_err, o_link} !== '0 || vcnt[0] + vcnt[1] != 0) begin
      errors++;
      $display("FAIL reset_release_idle: got data=%h cmd=%h link=%b valids=%0d, expected all 0",
               o_data, o_cmd, o_link, vcnt[0] + vcnt[1]);
    end
  endtask

  task automatic test_first_frame();
    int v0, v1;
    v0 = vcnt[0];
    v1 = vcnt[1];
    send_frame(0, 8'h05, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt[0] - v0 != 1) begin
      errors++;
      $display("FAIL ch0_valid_count: got %0d pulses, expected 1", vcnt[0] - v0);
    end
    checks++;
    if (o_data[7:0] !== 8'h05) begin
      errors++;
      $display("FAIL ch0_data: got %h, expected 05", o_data[7:0]);
    end
    checks++;
    if (o_cmd[6:0] !== 7'h05 || o_link[0] !== 1'b1) begin
      errors++;
      $display("FAIL ch0_cmd_link: got cmd=%h link=%b, expected cmd=05 link=1", o_cmd[6:0], o_link[0]);
    end
    checks++;
    if (vcnt[1] != v1 || o_data[15:8] !== 8'h00 || o_cmd[13:7] !== 7'h00 || o_link[1] !== 1'b0) begin
      errors++;
      $display("FAIL ch1_quiet: got valids=%0d data=%h cmd=%h link=%b, expected 0",
               vcnt[1] - v1, o_data[15:8], o_cmd[13:7], o_link[1]);
    end
  endtask

  task automatic test_hold_timeout();
    // Timer loads HOLD-1 on the edge that raises o_valid, so o_link and
    // o_cmd fall HOLD-1 cycles after the cycle where o_valid is seen.
    wait_link_low(0);
    checks++;
    if (o_link[0] !== 1'b0 || o_cmd[6:0] !== 7'h00) begin
      errors++;
      $display("FAIL hold_expire: got link=%b cmd=%h, expected 0 and 00", o_link[0], o_cmd[6:0]);
    end
    checks++;
    if (link_fall[0] - last_v[0] != HOLD - 1) begin
      errors++;
      $display("FAIL hold_length: got %0d cycles, expected %0d", link_fall[0] - last_v[0], HOLD - 1);
    end
    checks++;
    if (o_data[7:0] !== 8'h05) begin
      errors++;
      $display("FAIL data_kept_after_hold: got %h, expected 05", o_data[7:0]);
    end
  endtask

  task automatic test_frame_error();
    int e, v;
    e = ecnt[1];
    v = vcnt[1];
    send_frame(1, 8'h12, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ecnt[1] - e != 1 || vcnt[1] != v) begin
      errors++;
      $display("FAIL ch1_frame_err: got err_cycles=%0d valids=%0d, expected 1 and 0", ecnt[1] - e, vcnt[1] - v);
    end
    checks++;
    if (o_data[15:8] !== 8'h00 || o_cmd[13:7] !== 7'h00) begin
      errors++;
      $display("FAIL ch1_discard: got data=%h cmd=%h, expected 00 00", o_data[15:8], o_cmd[13:7]);
    end
    // Break: keep the line low for the rest of 40 bit times.
    repeat (39 * CPB - 4) @(negedge clk);
    checks++;
    if (ecnt[1] - e != 1 || vcnt[1] != v) begin
      errors++;
      $display("FAIL ch1_break_hold: got err_cycles=%0d valids=%0d, expected 1 and 0", ecnt[1] - e, vcnt[1] - v);
    end
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    send_frame(1, 8'h21, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt[1] - v != 1 || o_data[15:8] !== 8'h21 || o_cmd[13:7] !== 7'h21 || ecnt[1] - e != 1) begin
      errors++;
      $display("FAIL ch1_after_break: got valids=%0d data=%h cmd=%h errs=%0d, expected 1 21 21 1",
               vcnt[1] - v, o_data[15:8], o_cmd[13:7], ecnt[1] - e);
    end
  endtask

  task automatic test_glitch();
    int v, e;
    v = vcnt[0];
    e = ecnt[0];
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (vcnt[0] != v || ecnt[0] != e || o_data[7:0] !== 8'h05) begin
      errors++;
      $display("FAIL glitch_reject: got valids=%0d errs=%0d data=%h, expected 0 0 05",
               vcnt[0] - v, ecnt[0] - e, o_data[7:0]);
    end
    send_frame(0, 8'h40, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt[0] - v != 1 || o_cmd[6:0] !== 7'h40 || o_data[7:0] !== 8'h40) begin
      errors++;
      $display("FAIL after_glitch: got valids=%0d cmd=%h data=%h, expected 1 40 40",
               vcnt[0] - v, o_cmd[6:0], o_data[7:0]);
    end
  endtask

  task automatic test_control_byte();
    int v, t;
    v = vcnt[0];
    send_frame(0, 8'h03, 1'b1);
    t = last_v[0];
    send_bit(0, 1'b1);
    send_frame(0, 8'h80, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt[0] - v != 2 || o_data[7:0] !== 8'h80) begin
      errors++;
      $display("FAIL ctrl_valid: got valids=%0d data=%h, expected 2 80", vcnt[0] - v, o_data[7:0]);
    end
    checks++;
    if (o_cmd[6:0] !== 7'h03 || o_link[0] !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_cmd_kept: got cmd=%h link=%b, expected 03 1", o_cmd[6:0], o_link[0]);
    end
    wait_link_low(0);
    checks++;
    if (link_fall[0] - t != HOLD - 1 || o_cmd[6:0] !== 7'h00) begin
      errors++;
      $display("FAIL ctrl_no_reload: got hold=%0d cmd=%h, expected %0d 00", link_fall[0] - t, o_cmd[6:0], HOLD - 1);
    end
  endtask

  task automatic test_back_to_back_and_reset();
    int b, v0, v1, e0, e1;
    b = both_cnt;
    fork
      send_frame(0, 8'h11, 1'b1);
      send_frame(1, 8'h22, 1'b1);
    join
    // Second ch0 frame starts right after its stop bit.
    send_frame(0, 8'h2C, 1'b1);
    @(negedge clk);
    checks++;
    if (both_cnt - b != 1 || o_cmd !== {7'h22, 7'h2C} || o_data !== {8'h22, 8'h2C} || o_link !== 2'b11) begin
      errors++;
      $display("FAIL aligned_b2b: got both=%0d cmd=%h data=%h link=%b, expected 1 %h 222c 11",
               both_cnt - b, o_cmd, o_data, o_link, {7'h22, 7'h2C});
    end
    v0 = vcnt[0];
    v1 = vcnt[1];
    e0 = ecnt[0];
    e1 = ecnt[1];
    fork
      send_frame(0, 8'hF0, 1'b1);
      send_frame(1, 8'hF0, 1'b1);
      begin
        repeat (2 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_data, o_valid, o_cmd, o_frame_err, o_link} !== '0) begin
          errors++;
          $display("FAIL async_reset: got data=%h cmd=%h link=%b, expected all 0", o_data, o_cmd, o_link);
        end
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (vcnt[0] != v0 || vcnt[1] != v1 || ecnt[0] != e0 || ecnt[1] != e1 || o_data !== '0) begin
      errors++;
      $display("FAIL reset_remainder: got valids=%0d/%0d errs=%0d/%0d data=%h, expected none",
               vcnt[0] - v0, vcnt[1] - v1, ecnt[0] - e0, ecnt[1] - e1, o_data);
    end
    send_frame(0, 8'h0A, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt[0] - v0 != 1 || o_data[7:0] !== 8'h0A || o_cmd[6:0] !== 7'h0A || o_link !== 2'b01) begin
      errors++;
      $display("FAIL clean_after_reset: got valids=%0d data=%h cmd=%h link=%b, expected 1 0a 0a 01",
               vcnt[0] - v0, o_data[7:0], o_cmd[6:0], o_link);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hold_timeout();
    test_frame_error();
    test_glitch();
    test_control_byte();
    test_back_to_back_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
